// File: rtl/iccm_prog_loader_if.sv
// Byte-stream in / ICCM write-port out bundle for the boot-time program loader.
// master = loader side, slave = byte source and ICCM controller side.
interface iccm_prog_loader_if #(
    parameter int unsigned AW = 12
) ();
    logic [7:0]    rx_byte_i;
    logic          rx_valid_i;
    logic [AW-1:0] iccm_addr_o;
    logic [31:0]   iccm_wdata_o;
    logic          iccm_we_o;
    logic          prog_rst_no;
    logic          overflow_o;
    logic          timeout_o;

    modport master (
        input  rx_byte_i, rx_valid_i,
        output iccm_addr_o, iccm_wdata_o, iccm_we_o, prog_rst_no, overflow_o, timeout_o
    );

    modport slave (
        output rx_byte_i, rx_valid_i,
        input  iccm_addr_o, iccm_wdata_o, iccm_we_o, prog_rst_no, overflow_o, timeout_o
    );
endinterface

// File: rtl/iccm_prog_loader.sv
// Boot loader: assembles little-endian bytes into 32-bit ICCM writes and holds the core in
// reset until END_WORD arrives. Optional inter-byte timeout via `ICCM_PROG_TIMEOUT_EN.
module iccm_prog_loader #(
    parameter int unsigned AW       = 12,
    parameter logic [31:0] END_WORD = 32'h0000_0FFF,
    parameter int unsigned TO_CYC   = 1_000_000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    iccm_prog_loader_if.master bus
);
    typedef enum logic {LOAD, RUN} state_e;

    localparam logic [AW-1:0] ADDR_MAX = '1;

    state_e        state_q;
    logic [1:0]    cnt_q;
    logic [23:0]   asm_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic          full_q;
    logic          overflow_q;
    logic [31:0]   word;

    // Bytes 0..2 sit in asm_q; the 4th byte completes the word combinationally.
    assign word = {bus.rx_byte_i, asm_q};

`ifdef ICCM_PROG_TIMEOUT_EN
    logic [31:0] idle_q;
    logic        timeout_q;
    logic        idle_active;

    // we_q covers the cycle of the first write, before addr_q has moved off 0.
    assign idle_active = (state_q == LOAD) && !bus.rx_valid_i &&
                         ((cnt_q != 2'd0) || (addr_q != '0) || we_q || full_q);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= LOAD;
            cnt_q      <= 2'd0;
            asm_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef ICCM_PROG_TIMEOUT_EN
            idle_q     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;

            // Post-write address advance; the last location latches full instead of wrapping.
            if (we_q) begin
                if (addr_q == ADDR_MAX) full_q <= 1'b1;
                else                    addr_q <= addr_q + 1'b1;
            end

            if (bus.rx_valid_i) begin
                cnt_q <= cnt_q + 2'd1;
                asm_q <= {bus.rx_byte_i, asm_q[23:8]};
                if (state_q == RUN) state_q <= LOAD;

                if (cnt_q == 2'd3) begin
                    if (word == END_WORD) begin
                        state_q    <= RUN;
                        addr_q     <= '0;
                        full_q     <= 1'b0;
                        overflow_q <= 1'b0;
`ifdef ICCM_PROG_TIMEOUT_EN
                        timeout_q  <= 1'b0;
`endif
                    end else if (full_q) begin
                        overflow_q <= 1'b1;
                    end else begin
                        we_q    <= 1'b1;
                        wdata_q <= word;
                    end
                end
            end

`ifdef ICCM_PROG_TIMEOUT_EN
            if (idle_active) begin
                if (idle_q == TO_CYC - 1) begin
                    idle_q    <= '0;
                    timeout_q <= 1'b1;
                    cnt_q     <= 2'd0;
                    addr_q    <= '0;
                    full_q    <= 1'b0;
                end else begin
                    idle_q <= idle_q + 32'd1;
                end
            end else begin
                idle_q <= '0;
            end
`endif
        end
    end

    assign bus.iccm_addr_o  = addr_q;
    assign bus.iccm_wdata_o = wdata_q;
    assign bus.iccm_we_o    = we_q;
    assign bus.prog_rst_no  = (state_q == RUN);
    assign bus.overflow_o   = overflow_q;
`ifdef ICCM_PROG_TIMEOUT_EN
    assign bus.timeout_o    = timeout_q;
`else
    assign bus.timeout_o    = 1'b0;
`endif
endmodule
